// File: rtl/sky130_as_sc_hs_cell_bist.sv
// BIST sequencer: sweeps 16 vectors into one selected hs cell and checks it against a golden model.
// Optional build macro CELL_BIST_STOP_ON_FAIL_EN ends the run at the first mismatching vector.
module sky130_as_sc_hs_cell_bist #(
  parameter int N_CELLS    = 8,
  parameter int SETTLE_CYC = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic [2:0]         CELL_SEL,
  output logic [3:0]         DUT_IN,
  input  logic [N_CELLS-1:0] DUT_OUT,
  output logic               BUSY,
  output logic               DONE,
  output logic               PASS,
  output logic [4:0]         ERR_CNT,
  output logic [3:0]         FAIL_VEC
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_CHECK  = 2'd2,
    S_FIN    = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

  state_t     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [3:0] dut_in_q, dut_in_d;
  logic [3:0] cnt_q, cnt_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [4:0] err_cnt_q, err_cnt_d;
  logic [3:0] fail_vec_q, fail_vec_d;

  logic [7:0] gold_all;
  logic [7:0] cut_ext;
  logic       mismatch;
  logic       start_sel_ok;
  logic       run_sel_ok;

  function automatic logic golden(input logic [2:0] idx, input logic [3:0] v);
    logic a, b, c, d, g;
    a = v[0];
    b = v[1];
    c = v[2];
    d = v[3];
    g = 1'b0;
    case (idx)
      3'd0: g = ~a;
      3'd1: g = ~(a & b);
      3'd2: g = ~(a | b);
      3'd3: g = a ~^ b;
      3'd4: g = (a & b) | (b & c) | (a & c);
      3'd5: g = ~((a & b) | c | d);
      3'd6: g = ~((a | b) & c & d);
      3'd7: g = c ? b : a;
    endcase
    return g;
  endfunction

  for (genvar gi = 0; gi < 8; gi++) begin : g_gold
    assign gold_all[gi] = golden(3'(gi), dut_in_q);
  end

  // Unpopulated cell slots read as 0; they are never reached because such a selection skips to FIN.
  assign cut_ext      = 8'(DUT_OUT);
  assign mismatch     = cut_ext[sel_q] ^ gold_all[sel_q];
  assign start_sel_ok = int'(CELL_SEL) < N_CELLS;
  assign run_sel_ok   = int'(sel_q) < N_CELLS;

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    dut_in_d   = dut_in_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    err_cnt_d  = err_cnt_q;
    fail_vec_d = fail_vec_q;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          sel_d      = CELL_SEL;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          err_cnt_d  = '0;
          fail_vec_d = '0;
          dut_in_d   = '0;
          busy_d     = 1'b1;
          cnt_d      = '0;
          state_d    = start_sel_ok ? S_SETTLE : S_FIN;
        end
      end
      S_SETTLE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (mismatch) begin
          err_cnt_d = err_cnt_q + 5'd1;
          if (err_cnt_q == 5'd0) begin
            fail_vec_d = dut_in_q;
          end
        end
`ifdef CELL_BIST_STOP_ON_FAIL_EN
        if (mismatch || dut_in_q == 4'hF) begin
          state_d = S_FIN;
        end else begin
          dut_in_d = dut_in_q + 4'd1;
          cnt_d    = '0;
          state_d  = S_SETTLE;
        end
`else
        if (dut_in_q == 4'hF) begin
          state_d = S_FIN;
        end else begin
          dut_in_d = dut_in_q + 4'd1;
          cnt_d    = '0;
          state_d  = S_SETTLE;
        end
`endif
      end
      S_FIN: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = (err_cnt_q == 5'd0) && run_sel_ok;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      dut_in_q   <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_cnt_q  <= '0;
      fail_vec_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      dut_in_q   <= dut_in_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_cnt_q  <= err_cnt_d;
      fail_vec_q <= fail_vec_d;
    end
  end

  assign DUT_IN   = dut_in_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign PASS     = pass_q;
  assign ERR_CNT  = err_cnt_q;
  assign FAIL_VEC = fail_vec_q;

endmodule

// File: tb/tb_sky130_as_sc_hs_cell_bist.sv
// Bench for the cell BIST: behavioural CUTs with injectable faults, run table plus scoreboard.
// Latencies count rising edges starting with the edge that samples START as edge 1.
module tb_sky130_as_sc_hs_cell_bist;

  localparam int SC  = 2;
  localparam int PER = SC + 1;

  // Truth tables, bit v = cell output for vector v (v[0]=A .. v[3]=D).
  localparam logic [15:0] TT [8] = '{16'h5555, 16'h7777, 16'h1111, 16'h9999,
                                     16'hE8E8, 16'h0007, 16'h1FFF, 16'hCACA};

  typedef struct {
    bit         use4;
    logic [2:0] sel;
    int         fault;
    int         exp_pass;
    int         exp_err;
    int         exp_fv;
    int         exp_lat;
    int         exp_din;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst, start, start4;
  logic [2:0] cell_sel, cell_sel4;
  logic [3:0] dut_in, dut_in4, fail_vec, fail_vec4;
  logic [7:0] dut_out;
  logic [3:0] dut_out4;
  logic       busy, done, pass, busy4, done4, pass4;
  logic [4:0] err_cnt, err_cnt4;
  int         fault_mode;

  int   n_vec = 0;
  int   n_mis = 0;
  vec_t tbl [11];
  vec_t sb_q [$];

  always #5 clk = ~clk;

  sky130_as_sc_hs_cell_bist #(.N_CELLS(8), .SETTLE_CYC(SC)) dut (
    .CLK(clk), .RST(rst), .START(start), .CELL_SEL(cell_sel), .DUT_IN(dut_in),
    .DUT_OUT(dut_out), .BUSY(busy), .DONE(done), .PASS(pass), .ERR_CNT(err_cnt),
    .FAIL_VEC(fail_vec)
  );

  sky130_as_sc_hs_cell_bist #(.N_CELLS(4), .SETTLE_CYC(SC)) dut4 (
    .CLK(clk), .RST(rst), .START(start4), .CELL_SEL(cell_sel4), .DUT_IN(dut_in4),
    .DUT_OUT(dut_out4), .BUSY(busy4), .DONE(done4), .PASS(pass4), .ERR_CNT(err_cnt4),
    .FAIL_VEC(fail_vec4)
  );

  function automatic logic cut_good(input int c, input logic [3:0] v);
    logic [15:0] t;
    t = TT[c];
    return t[v];
  endfunction

  always_comb begin
    dut_out = '0;
    for (int c = 0; c < 8; c++) dut_out[c] = cut_good(c, dut_in);
    case (fault_mode)
      1: dut_out[4] = 1'b0;
      2: dut_out[7] = dut_in[2] ? dut_in[0] : dut_in[1];
      3: dut_out[0] = 1'b1;
      4: dut_out[3] = ~cut_good(3, dut_in);
      5: if (dut_in == 4'hF) dut_out[6] = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    dut_out4 = '0;
    for (int c = 0; c < 4; c++) dut_out4[c] = cut_good(c, dut_in4);
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t adj(input vec_t v);
    vec_t r;
    r = v;
`ifdef CELL_BIST_STOP_ON_FAIL_EN
    if (v.exp_err != 0) begin
      r.exp_err = 1;
      r.exp_lat = PER * (v.exp_fv + 1) + 2;
      r.exp_din = v.exp_fv;
    end
`endif
    return r;
  endfunction

  task automatic do_run(input vec_t v);
    vec_t e;
    int   lat;
    int   b, d, p, ec, fv, di;
    sb_q.push_back(v);
    @(negedge clk);
    fault_mode = v.fault;
    if (v.use4) begin
      cell_sel4 = v.sel;
      start4    = 1'b1;
    end else begin
      cell_sel = v.sel;
      start    = 1'b1;
    end
    @(posedge clk);
    #1;
    start  = 1'b0;
    start4 = 1'b0;
    lat    = 1;
    check("busy_after_start", v.use4 ? int'(busy4) : int'(busy), 1);
    check("done_cleared_at_start", v.use4 ? int'(done4) : int'(done), 0);
    while ((v.use4 ? done4 : done) == 1'b0 && lat < 200) begin
      cell_sel  = 3'($urandom);
      cell_sel4 = 3'($urandom);
      @(posedge clk);
      #1;
      lat++;
    end
    if (v.use4) begin
      b = busy4; d = done4; p = pass4; ec = err_cnt4; fv = fail_vec4; di = dut_in4;
    end else begin
      b = busy; d = done; p = pass; ec = err_cnt; fv = fail_vec; di = dut_in;
    end
    e = sb_q.pop_front();
    check("done_seen", d, 1);
    check("latency", lat, e.exp_lat);
    check("busy_at_done", b, 0);
    check("pass", p, e.exp_pass);
    check("err_cnt", ec, e.exp_err);
    check("fail_vec", fv, e.exp_fv);
    check("dut_in_at_done", di, e.exp_din);
    $display("run dut%0d sel=%0d fault=%0d: lat=%0d pass=%0d err=%0d fail_vec=%h dut_in=%h",
             v.use4 ? 4 : 8, v.sel, v.fault, lat, p, ec, fv, di);
  endtask

  initial begin
    int   lat;
    int   bad;
    vec_t v;

    //           use4  sel   flt pass err fv  lat din
    tbl[0]  = '{1'b0, 3'd1, 0, 1,  0,  0,  50, 15};
    tbl[1]  = '{1'b0, 3'd4, 1, 0,  8,  3,  50, 15};
    tbl[2]  = '{1'b0, 3'd7, 2, 0,  8,  1,  50, 15};
    tbl[3]  = '{1'b0, 3'd0, 3, 0,  8,  1,  50, 15};
    tbl[4]  = '{1'b0, 3'd3, 4, 0,  16, 0,  50, 15};
    tbl[5]  = '{1'b0, 3'd6, 5, 0,  1,  15, 50, 15};
    tbl[6]  = '{1'b0, 3'd5, 0, 1,  0,  0,  50, 15};
    tbl[7]  = '{1'b0, 3'd2, 0, 1,  0,  0,  50, 15};
    tbl[8]  = '{1'b1, 3'd5, 0, 0,  0,  0,  2,  0};
    tbl[9]  = '{1'b1, 3'd3, 0, 1,  0,  0,  50, 15};
    tbl[10] = '{1'b0, 3'd7, 0, 1,  0,  0,  50, 15};

    rst = 1'b1; start = 1'b0; start4 = 1'b0;
    cell_sel = '0; cell_sel4 = '0; fault_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_fail_vec", fail_vec, 0);
    check("rst_dut_in", dut_in, 0);
    check("rst_done4", done4, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) do_run(adj(tbl[i]));

    // Abort: reset held 3 cycles in the middle of a run.
    @(negedge clk);
    fault_mode = 0; cell_sel = 3'd1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("midrun_busy", busy, 1);
    check("midrun_dut_in_moved", int'(dut_in != 4'h0), 1);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_err_cnt", err_cnt, 0);
    check("abort_fail_vec", fail_vec, 0);
    check("abort_dut_in", dut_in, 0);
    bad = 0;
    repeat (60) begin
      @(posedge clk);
      #1;
      if (done || busy) bad++;
    end
    check("abort_no_done", bad, 0);
    $display("abort sequence: stray busy/done cycles=%0d", bad);
    do_run(adj(tbl[0]));

    // START pulses while busy: once at edge 5 and once on the FIN edge.
    @(negedge clk);
    fault_mode = 0; cell_sel = 3'd2; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 1;
    while (lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
      start = (lat == 4 || lat == 49);
    end
    start = 1'b0;
    check("ignored_start_done", done, 1);
    check("ignored_start_pass", pass, 1);
    check("ignored_start_busy", busy, 0);
    bad = 0;
    repeat (60) begin
      @(posedge clk);
      #1;
      if (!done || busy) bad++;
    end
    check("single_done", bad, 0);
    $display("ignored-start sequence: done at %0d, disturbed cycles=%0d", lat, bad);

    // Back-to-back restart while DONE is still high.
    v = tbl[7];
    do_run(adj(v));

    check("scoreboard_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
